// File: rtl/puf_readout_ctrl_pkg.sv
// puf_ctrl_pkg: shared constants and state encoding for the PUF readout
// sequencer.
//   - state encoding localparams and the matching state_t enum
//   - UART command codes
//   - Hamming-weight accumulator width
package puf_ctrl_pkg;

  localparam int HW_ACC_W = 18;

  localparam logic [7:0] CMD_DUMP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_RANGE = 8'h72;  // 'r'
  localparam logic [7:0] CMD_HW    = 8'h68;  // 'h'

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ARG      = 4'd1;
  localparam logic [3:0] S_RD_ADDR  = 4'd2;
  localparam logic [3:0] S_RD_WAIT  = 4'd3;
  localparam logic [3:0] S_LATCH    = 4'd4;
  localparam logic [3:0] S_TX_WAIT  = 4'd5;
  localparam logic [3:0] S_TX_PULSE = 4'd6;
  localparam logic [3:0] S_TX_GUARD = 4'd7;
  localparam logic [3:0] S_TX_DRAIN = 4'd8;
  localparam logic [3:0] S_NEXT     = 4'd9;
  localparam logic [3:0] S_HW_SCAN  = 4'd10;
  localparam logic [3:0] S_HW_LOAD  = 4'd11;
  localparam logic [3:0] S_HW_NEXT  = 4'd12;

  typedef enum logic [3:0] {
    ST_IDLE     = S_IDLE,
    ST_ARG      = S_ARG,
    ST_RD_ADDR  = S_RD_ADDR,
    ST_RD_WAIT  = S_RD_WAIT,
    ST_LATCH    = S_LATCH,
    ST_TX_WAIT  = S_TX_WAIT,
    ST_TX_PULSE = S_TX_PULSE,
    ST_TX_GUARD = S_TX_GUARD,
    ST_TX_DRAIN = S_TX_DRAIN,
    ST_NEXT     = S_NEXT,
    ST_HW_SCAN  = S_HW_SCAN,
    ST_HW_LOAD  = S_HW_LOAD,
    ST_HW_NEXT  = S_HW_NEXT
  } state_t;

endpackage

// File: rtl/puf_readout_ctrl_if.sv
// puf_readout_ctrl_if: UART byte interface plus PUF SRAM ports.
//   master : the readout sequencer (drives tx strobe/data and SRAM address)
//   slave  : UART + SRAM side (drives rx strobe/data, tx ready, read data)
//   raddr/waddr are word addresses (ADDR_W-1 bits), data is 16-bit.
interface puf_readout_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              uart_rx_ready;
  logic [7:0]        uart_data_from_rx;
  logic              uart_tx_ready;
  logic              uart_tx_enable;
  logic [7:0]        uart_data_to_tx;
  logic [ADDR_W-2:0] raddr;
  logic [15:0]       rdata;
  logic              we;
  logic [ADDR_W-2:0] waddr;
  logic [15:0]       wdata;
  logic [15:0]       wmask;

  modport master (
    input  uart_rx_ready, uart_data_from_rx, uart_tx_ready, rdata,
    output uart_tx_enable, uart_data_to_tx, raddr, we, waddr, wdata, wmask
  );

  modport slave (
    output uart_rx_ready, uart_data_from_rx, uart_tx_ready, rdata,
    input  uart_tx_enable, uart_data_to_tx, raddr, we, waddr, wdata, wmask
  );
endinterface

// File: rtl/puf_readout_ctrl_popcount16.sv
// popcount16: combinational population count of a 16-bit word.
//   din : input word
//   cnt : number of set bits (0..16)
module popcount16 (
  input  logic [15:0] din,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(din[i]);
    end
  end
endmodule

// File: rtl/puf_readout_ctrl.sv
// puf_readout_ctrl: command-driven readout of the PUF SRAM over UART.
//   clk, rst_n : system clock, async active-low reset
//   bus        : UART rx/tx handshake and SRAM read port (write port tied off)
//   busy       : high whenever an operation is in progress (not IDLE/ARG)
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | wait for a command byte
// ARG        | collect addr_hi, addr_lo, len for a ranged dump
// RD_ADDR    | present word address of current byte
// RD_WAIT    | SRAM read latency
// LATCH      | capture selected byte into the tx register
// TX_WAIT    | wait for transmitter idle
// TX_PULSE   | one-cycle tx enable
// TX_GUARD   | 2 cycles for tx ready to drop
// TX_DRAIN   | wait for transmitter idle, then return via ret_state
// NEXT       | advance byte index / remaining count
// HW_SCAN    | stream all words, accumulate popcount
// HW_LOAD    | load next accumulator byte (MSB first)
// HW_NEXT    | advance accumulator byte select
module puf_readout_ctrl
  import puf_ctrl_pkg::*;
#(
  parameter int PUF_BYTES   = 16384,
  parameter int ADDR_W      = 14,
  parameter int ARG_TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  puf_readout_ctrl_if.master  bus,
  output logic                busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int WORDS = PUF_BYTES / 2;
  localparam int TMR_W = $clog2(ARG_TIMEOUT + 1);

  state_t state, state_nxt, ret_state;

  logic [ADDR_W-1:0]   idx;
  logic [CNT_W-1:0]    count;
  logic [1:0]          arg_cnt;
  logic [7:0]          arg_hi, arg_lo;
  logic [TMR_W-1:0]    timer;
  logic [HW_ACC_W-1:0] acc;
  logic [ADDR_W-1:0]   scan_cnt;
  logic [1:0]          hw_sel;
  logic                guard;
  logic [ADDR_W-2:0]   raddr_q;
  logic [7:0]          tx_data_q;
  logic [4:0]          pop;
  logic                tx_enable;

  popcount16 u_popcount (
    .din (bus.rdata),
    .cnt (pop)
  );

  assign bus.uart_tx_enable  = tx_enable;
  assign bus.uart_data_to_tx = tx_data_q;
  assign bus.raddr           = raddr_q;
  // Write port permanently idle: the power-up content is the PUF response.
  assign bus.we              = 1'b0;
  assign bus.waddr           = '0;
  assign bus.wdata           = '0;
  assign bus.wmask           = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_enable = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.uart_rx_ready) begin
          case (bus.uart_data_from_rx)
            CMD_DUMP:  state_nxt = ST_RD_ADDR;
            CMD_RANGE: state_nxt = ST_ARG;
            CMD_HW:    state_nxt = ST_HW_SCAN;
            default:   state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_ARG: begin
        busy = 1'b0;
        if (bus.uart_rx_ready) begin
          if (arg_cnt == 2'd2) state_nxt = ST_RD_ADDR;
        end else if (timer == '0) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_ADDR:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  state_nxt = ST_LATCH;
      ST_LATCH:    state_nxt = ST_TX_WAIT;
      ST_TX_WAIT:  if (bus.uart_tx_ready) state_nxt = ST_TX_PULSE;
      ST_TX_PULSE: begin
        tx_enable = 1'b1;
        state_nxt = ST_TX_GUARD;
      end
      ST_TX_GUARD: if (guard) state_nxt = ST_TX_DRAIN;
      ST_TX_DRAIN: if (bus.uart_tx_ready) state_nxt = ret_state;
      ST_NEXT:     state_nxt = (count == CNT_W'(1)) ? ST_IDLE : ST_RD_ADDR;
      ST_HW_SCAN:  if (scan_cnt == ADDR_W'(WORDS)) state_nxt = ST_HW_LOAD;
      ST_HW_LOAD:  state_nxt = ST_TX_WAIT;
      ST_HW_NEXT:  state_nxt = (hw_sel == 2'd2) ? ST_IDLE : ST_HW_LOAD;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_state <= ST_NEXT;
      idx       <= '0;
      count     <= '0;
      arg_cnt   <= '0;
      arg_hi    <= '0;
      arg_lo    <= '0;
      timer     <= '0;
      acc       <= '0;
      scan_cnt  <= '0;
      hw_sel    <= '0;
      guard     <= 1'b0;
      raddr_q   <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.uart_rx_ready) begin
            if (bus.uart_data_from_rx == CMD_DUMP) begin
              idx       <= '0;
              count     <= CNT_W'(PUF_BYTES);
              ret_state <= ST_NEXT;
            end
            if (bus.uart_data_from_rx == CMD_RANGE) begin
              arg_cnt <= '0;
              timer   <= TMR_W'(ARG_TIMEOUT - 1);
            end
            if (bus.uart_data_from_rx == CMD_HW) begin
              acc       <= '0;
              scan_cnt  <= '0;
              raddr_q   <= '0;
              hw_sel    <= '0;
              ret_state <= ST_HW_NEXT;
            end
          end
        end
        ST_ARG: begin
          if (bus.uart_rx_ready) begin
            timer   <= TMR_W'(ARG_TIMEOUT - 1);
            arg_cnt <= arg_cnt + 2'd1;
            case (arg_cnt)
              2'd0:    arg_hi <= bus.uart_data_from_rx;
              2'd1:    arg_lo <= bus.uart_data_from_rx;
              default: begin
                // Upper address bits beyond the array size are dropped.
                idx       <= ADDR_W'({arg_hi, arg_lo});
                count     <= (bus.uart_data_from_rx == 8'd0) ? CNT_W'(256)
                                                             : CNT_W'(bus.uart_data_from_rx);
                ret_state <= ST_NEXT;
              end
            endcase
          end else if (timer == '0) begin
            arg_cnt <= '0;
            arg_hi  <= '0;
            arg_lo  <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_RD_ADDR:  raddr_q <= idx[ADDR_W-1:1];
        ST_LATCH:    tx_data_q <= idx[0] ? bus.rdata[15:8] : bus.rdata[7:0];
        ST_TX_PULSE: guard <= 1'b0;
        ST_TX_GUARD: guard <= ~guard;
        ST_NEXT: begin
          count <= count - 1'b1;
          // idx is exactly ADDR_W bits, so +1 wraps at PUF_BYTES.
          if (count != CNT_W'(1)) idx <= idx + 1'b1;
        end
        ST_HW_SCAN: begin
          scan_cnt <= scan_cnt + 1'b1;
          raddr_q  <= raddr_q + 1'b1;
          // rdata lags raddr by one cycle, so the first scan cycle has nothing to add.
          if (scan_cnt != '0) acc <= acc + HW_ACC_W'(pop);
        end
        ST_HW_LOAD: begin
          case (hw_sel)
            2'd0:    tx_data_q <= {6'b0, acc[17:16]};
            2'd1:    tx_data_q <= acc[15:8];
            default: tx_data_q <= acc[7:0];
          endcase
        end
        ST_HW_NEXT: hw_sel <= hw_sel + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_readout_ctrl.sv
module tb_puf_readout_ctrl;
  localparam int PUF_BYTES   = 512;
  localparam int ADDR_W      = 9;
  localparam int ARG_TIMEOUT = 64;
  localparam int WORDS       = PUF_BYTES / 2;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  puf_readout_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  puf_readout_ctrl #(
    .PUF_BYTES   (PUF_BYTES),
    .ADDR_W      (ADDR_W),
    .ARG_TIMEOUT (ARG_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [WORDS];
  always @(posedge clk) bus.rdata <= mem[bus.raddr];

  int checks = 0;
  int errors = 0;
  int we_bad = 0;
  int dbl_en = 0;
  bit en_prev = 0;
  bit tx_hold = 0;
  int tx_busy_cnt = 0;
  logic [7:0] tx_q [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: captures each enable pulse, then stays not-ready
  // for a random 1..5 cycles (or indefinitely while tx_hold is set).
  always @(negedge clk) begin
    if (bus.we !== 1'b0 || bus.waddr !== '0 || bus.wdata !== '0 || bus.wmask !== '0)
      we_bad++;
    if (!rst_n) begin
      bus.uart_tx_ready = 1'b1;
      tx_busy_cnt = 0;
      en_prev = 0;
    end else begin
      if (bus.uart_tx_enable && en_prev) dbl_en++;
      en_prev = bus.uart_tx_enable;
      if (bus.uart_tx_enable) begin
        tx_q.push_back(bus.uart_data_to_tx);
        tx_busy_cnt = $urandom_range(1, 5);
        bus.uart_tx_ready = 1'b0;
      end else if (tx_busy_cnt > 0) begin
        tx_busy_cnt--;
        if (tx_busy_cnt == 0 && !tx_hold) bus.uart_tx_ready = 1'b1;
      end else if (!tx_hold) begin
        bus.uart_tx_ready = 1'b1;
      end
    end
  end

  function automatic logic [7:0] ref_byte(input int b);
    logic [15:0] w;
    w = mem[(b % PUF_BYTES) / 2];
    return (b % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic build_stream(input int start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(ref_byte(start + i));
  endtask

  task automatic build_hw();
    int sum;
    sum = 0;
    for (int i = 0; i < WORDS; i++) sum += $countones(mem[i]);
    exp_q.delete();
    exp_q.push_back(8'((sum >> 16) & 3));
    exp_q.push_back(8'((sum >> 8) & 255));
    exp_q.push_back(8'(sum & 255));
  endtask

  task automatic compare_q(input string tag);
    int n;
    chk({tag, "_len"}, tx_q.size(), exp_q.size());
    n = (tx_q.size() < exp_q.size()) ? tx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk(tag, tx_q[i], exp_q[i]);
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_ready = 1'b1;
    bus.uart_data_from_rx = b;
    @(negedge clk);
    bus.uart_rx_ready = 1'b0;
    bus.uart_data_from_rx = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic run_range(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] len);
    tx_q.delete();
    send_byte(8'h72);
    send_byte(hi);
    send_byte(lo);
    send_byte(len);
    wait_idle(tag, 20000);
  endtask

  initial begin
    int start, len, n;
    rst_n = 1'b0;
    bus.uart_rx_ready = 1'b0;
    bus.uart_data_from_rx = 8'h00;
    for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA55A;
    mem[1] = 16'h1234;
    mem[WORDS-1][15:8] = 8'hEE;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", bus.uart_tx_enable, 0);
    chk("rst_tx_data", bus.uart_data_to_tx, 0);
    chk("rst_raddr", bus.raddr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full dump
    tx_q.delete();
    send_byte(8'h73);
    wait_idle("dump1", 40000);
    chk("dump1_b0", tx_at(0), 32'h5A);
    chk("dump1_b1", tx_at(1), 32'hA5);
    chk("dump1_b2", tx_at(2), 32'h34);
    chk("dump1_b3", tx_at(3), 32'h12);
    build_stream(0, PUF_BYTES);
    compare_q("dump1");
    chk("dump1_busy_end", busy, 0);

    // ranged dump crossing the top of the array; upper address bits ignored
    run_range("wrap", 8'h3F, 8'hFF, 8'h03);
    chk("wrap_len", tx_q.size(), 3);
    chk("wrap_b0", tx_at(0), 32'hEE);
    chk("wrap_b1", tx_at(1), 32'h5A);
    chk("wrap_b2", tx_at(2), 32'hA5);
    chk("wrap_busy", busy, 0);

    // len 0 means 256
    run_range("len0", 8'h00, 8'h00, 8'h00);
    build_stream(0, 256);
    compare_q("len0");

    // random ranged dumps
    for (int k = 0; k < 6; k++) begin
      start = $urandom_range(0, 65535);
      len   = $urandom_range(1, 40);
      run_range("rand_rng", 8'(start >> 8), 8'(start), 8'(len));
      build_stream(start % PUF_BYTES, len);
      compare_q("rand_rng");
    end

    // Hamming-weight scans
    for (int i = 0; i < WORDS; i++) mem[i] = 16'hFFFF;
    tx_q.delete();
    send_byte(8'h68);
    wait_idle("hw_ones", 5000);
    build_hw();
    compare_q("hw_ones");
    for (int i = 0; i < WORDS; i++) mem[i] = 16'h0001;
    tx_q.delete();
    send_byte(8'h68);
    wait_idle("hw_lsb", 5000);
    build_hw();
    compare_q("hw_lsb");
    for (int i = 0; i < WORDS; i++) mem[i] = 16'($urandom);
    tx_q.delete();
    send_byte(8'h68);
    wait_idle("hw_rand", 5000);
    build_hw();
    compare_q("hw_rand");

    // argument timeout, then a normal dump
    tx_q.delete();
    send_byte(8'h72);
    send_byte(8'h00);
    repeat (ARG_TIMEOUT + 2) @(negedge clk);
    chk("tmo_no_tx", tx_q.size(), 0);
    chk("tmo_busy", busy, 0);
    send_byte(8'h73);
    wait_idle("tmo_dump", 40000);
    build_stream(0, PUF_BYTES);
    compare_q("tmo_dump");

    // unknown command in IDLE
    tx_q.delete();
    send_byte(8'h78);
    repeat (20) @(negedge clk);
    chk("bad_cmd_busy", busy, 0);
    chk("bad_cmd_tx", tx_q.size(), 0);

    // commands sent during a dump are dropped
    tx_q.delete();
    send_byte(8'h73);
    repeat (100) @(negedge clk);
    send_byte(8'h73);
    send_byte(8'h78);
    send_byte(8'h68);
    send_byte(8'h72);
    wait_idle("busy_drop", 40000);
    build_stream(0, PUF_BYTES);
    compare_q("busy_drop");

    // reset mid-dump while a transmit is pending
    tx_q.delete();
    send_byte(8'h73);
    n = 0;
    while (tx_q.size() < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_progress_timeout", 32'(n >= 2000), 0);
    tx_hold = 1;
    repeat (20) @(negedge clk);
    chk("mid_rst_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_en", bus.uart_tx_enable, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_raddr", bus.raddr, 0);
    chk("mid_rst_tx_data", bus.uart_data_to_tx, 0);
    @(negedge clk);
    tx_hold = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_q.delete();
    send_byte(8'h73);
    wait_idle("post_rst", 40000);
    build_stream(0, PUF_BYTES);
    compare_q("post_rst");

    chk("we_tied_off", we_bad, 0);
    chk("tx_en_single", dbl_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/puf_readout_ctrl.md
Name: puf_readout_ctrl

Overview:
Command-driven sequencer between the UART byte interface and the read port of the PUF SRAM (combined_ram). It parses single-byte commands plus arguments from the UART receiver and sequences SRAM word reads, byte selection and UART transmit handshakes for three operations: full dump, ranged dump, and Hamming-weight scan. It replaces the fixed dump-only state machine in the top level. The SRAM write port is tied off because the power-up content must never be disturbed.

Parameters:
PUF_BYTES, 16384, number of readable SRAM bytes; must be a power of 2
ADDR_W, 14, byte-address width, log2(PUF_BYTES)
ARG_TIMEOUT, 1000000, clock cycles allowed between argument bytes before an 'r' command is abandoned

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx_ready  in  1  one-cycle strobe; uart_data_from_rx is valid in that cycle
uart_data_from_rx  in  8  received byte
uart_tx_ready  in  1  high when the transmitter is idle
uart_tx_enable  out  1  one-cycle pulse that launches transmission of uart_data_to_tx
uart_data_to_tx  out  8  registered byte; held stable until uart_tx_ready returns high
raddr  out  ADDR_W-1  SRAM word read address
rdata  in  16  SRAM read data; valid 1 cycle after raddr
we  out  1  constant 0
waddr  out  ADDR_W-1  constant 0
wdata  out  16  constant 0
wmask  out  16  constant 0
busy  out  1  high in every state except IDLE and ARG

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - uart_tx_enable=0, uart_data_to_tx=0x00, raddr=0, busy=0.
  - Byte index, remaining count, argument registers and accumulator clear to 0.
- Reset mid-operation aborts the operation immediately. No partial byte is retried.
- Commands are accepted only in IDLE, on uart_rx_ready=1:
  - 's' (0x73): start = 0, count = PUF_BYTES, go to RD_ADDR.
  - 'r' (0x72): go to ARG. The next three received bytes are addr_hi, addr_lo and len.
    - start = {addr_hi, addr_lo}[ADDR_W-1:0]; upper bits are ignored.
    - count = len, except len = 0 means 256.
  - 'h' (0x68): go to HW_SCAN.
  - Any other byte is ignored and the state stays IDLE.
- Received bytes in any state other than IDLE and ARG are dropped.
- ARG state:
  - A cycle counter resets on each received byte.
  - If the counter reaches ARG_TIMEOUT, the argument bytes are discarded and the state returns to IDLE with no output.
  - On the third argument byte, go to RD_ADDR.
- Byte stream path (states in order):
  - RD_ADDR: raddr = idx[ADDR_W-1:1].
  - RD_WAIT: one cycle for the SRAM read latency.
  - LATCH: uart_data_to_tx = idx[0] ? rdata[15:8] : rdata[7:0].
  - TX_WAIT: wait for uart_tx_ready=1.
  - TX_PULSE: uart_tx_enable=1 for exactly one cycle.
  - TX_GUARD: 2 cycles, so ready has time to drop.
  - TX_DRAIN: wait for uart_tx_ready=1.
  - NEXT: decrement count. If count is now 0, go to IDLE. Otherwise idx = (idx+1) mod PUF_BYTES and go to RD_ADDR.
- Wrap: a ranged read that crosses PUF_BYTES-1 continues at byte 0.
- HW_SCAN:
  - Issue raddr = 0..PUF_BYTES/2-1, one word per cycle.
  - Add popcount(rdata) to an 18-bit accumulator one cycle after each address.
  - The scan takes PUF_BYTES/2+1 cycles. The accumulator is cleared on entry.
  - Then send 3 bytes, most significant first: {6'b0, acc[17:16]}, acc[15:8], acc[7:0]. These use the same TX_WAIT/TX_PULSE/TX_GUARD/TX_DRAIN handshake.
  - Then go to IDLE.
- uart_tx_enable is never high for two consecutive cycles and never high outside TX_PULSE.
- we is never 1, in any state and during reset.

Decomposition:
- Package puf_ctrl_pkg holds:
  - the state encoding localparams;
  - command codes CMD_DUMP=0x73, CMD_RANGE=0x72, CMD_HW=0x68;
  - the HW accumulator width of 18.
- Sub-module popcount16: purely combinational, 16-bit in, 5-bit out. It is instanced once for the scan datapath.
- The TX handshake is shared by both paths through a return-state register. It is not a separate module.

Test Plan:
- SRAM word0=0xA55A, word1=0x1234, send 's' -> first four tx bytes 0x5A, 0xA5, 0x34, 0x12; exactly 16384 enable pulses; busy falls after the last byte.
- Send 'r', 0x3F, 0xFF, 0x03 with byte 16383=0xEE, word0=0xA55A -> tx 0xEE, 0x5A, 0xA5 (wrap-around), then IDLE.
- Send 'r', 0x00, 0x00, 0x00 -> exactly 256 bytes sent (len 0 = 256).
- SRAM all 0xFFFF, send 'h' -> tx 0x02, 0x00, 0x00. SRAM all 0x0001, send 'h' -> tx 0x00, 0x20, 0x00.
- Send 'r', 0x00, then idle ARG_TIMEOUT+2 cycles -> no tx. A following 's' dumps normally. Sending 'x', or sending 's' during a dump -> ignored, dump byte count unchanged.
- Assert rst_n=0 mid-dump while uart_tx_enable is pending -> enable=0 and busy=0 at once. After release, 's' restarts from byte 0. A monitor confirms we=0 and uart_tx_enable is a single-cycle pulse throughout.
